// File: rtl/wbs_regmap_pkg.sv
// Shared definitions for the Wishbone register map: page offsets, window codes,
// register selects, FSM states and the node word layout.
package wbs_regmap_pkg;

    localparam logic [15:0] OFF_MODE  = 16'h0000;
    localparam logic [15:0] OFF_DEBUG = 16'h0004;
    localparam logic [15:0] OFF_DONE  = 16'h0008;
    localparam logic [15:0] OFF_START = 16'h000C;
    localparam logic [15:0] OFF_BUSY  = 16'h0010;

    localparam int unsigned NODE_IDX_LSB = 0;
    localparam int unsigned NODE_IDX_W   = 11;
    localparam int unsigned NODE_MED_LSB = 11;
    localparam int unsigned NODE_MED_W   = 11;

    typedef enum logic [1:0] {
        WIN_QUERY = 2'd0,
        WIN_LEAF  = 2'd1,
        WIN_BEST  = 2'd2,
        WIN_NODE  = 2'd3
    } win_e;

    typedef enum logic [2:0] {
        REG_MODE  = 3'd0,
        REG_DEBUG = 3'd1,
        REG_DONE  = 3'd2,
        REG_START = 3'd3,
        REG_BUSY  = 3'd4
    } reg_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REG   = 3'd1,
        ST_MREQ  = 3'd2,
        ST_MWAIT = 3'd3,
        ST_ACK   = 3'd4
    } state_e;

    typedef struct packed {
        logic is_reg;
        reg_e reg_sel;
        logic is_win;
        win_e win;
        logic unmapped;
    } dec_t;

endpackage

// File: rtl/wbs_addr_decode.sv
// Combinational byte-address decode into register page, memory window or unmapped.
module wbs_addr_decode
    import wbs_regmap_pkg::*;
#(
    parameter logic [15:0] BASE_HI = 16'h3000
) (
    input  logic [31:0] i_adr,
    output dec_t        o_dec_c
);

    logic [15:0] w_hi_off;

    assign w_hi_off = i_adr[31:16] - BASE_HI;

    always_comb begin
        o_dec_c = '0;
        if (w_hi_off == 16'd0) begin
            // Exact offsets only; adr[1:0] is never treated as a byte offset.
            o_dec_c.is_reg = 1'b1;
            case (i_adr[15:0])
                OFF_MODE:  o_dec_c.reg_sel = REG_MODE;
                OFF_DEBUG: o_dec_c.reg_sel = REG_DEBUG;
                OFF_DONE:  o_dec_c.reg_sel = REG_DONE;
                OFF_START: o_dec_c.reg_sel = REG_START;
                OFF_BUSY:  o_dec_c.reg_sel = REG_BUSY;
                default: begin
                    o_dec_c.is_reg   = 1'b0;
                    o_dec_c.unmapped = 1'b1;
                end
            endcase
        end else if (w_hi_off >= 16'd1 && w_hi_off <= 16'd4) begin
            o_dec_c.is_win = 1'b1;
            o_dec_c.win    = win_e'(2'(w_hi_off - 16'd1));
        end else begin
            o_dec_c.unmapped = 1'b1;
        end
    end

endmodule

// File: rtl/wbs_slave_regmap.sv
// Wishbone-classic responder: control registers on the base page and a bridge
// from four address windows onto a fixed-latency memory request port.
module wbs_slave_regmap
    import wbs_regmap_pkg::*;
#(
    parameter int unsigned MEM_AW  = 12,
    parameter int unsigned MEM_LAT = 1,
    parameter logic [15:0] BASE_HI = 16'h3000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              mode_o,
    output logic [31:0]       debug_o,
    output logic              fsm_start_o,
    input  logic              fsm_done_i,
    input  logic              fsm_busy_i,
    output logic              mem_req_o,
    output logic [1:0]        mem_win_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              unmapped_o
);

    localparam int unsigned CNT_W = 2;

    state_e            r_state;
    reg_e              r_reg_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_mode;
    logic [31:0]       r_debug;
    logic              r_start;
    logic              r_mem_req;
    win_e              r_mem_win;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;
    logic              r_unmapped;

    dec_t w_dec;
    logic w_act;

    assign w_act = wbs_cyc_i & wbs_stb_i;

    wbs_addr_decode #(.BASE_HI(BASE_HI)) u_dec (
        .i_adr   (wbs_adr_i),
        .o_dec_c (w_dec)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_reg_sel   <= REG_MODE;
            r_cnt       <= '0;
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_mode      <= 1'b0;
            r_debug     <= '0;
            r_start     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_win   <= WIN_QUERY;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_unmapped  <= 1'b0;
        end else begin
            // Pulse-style outputs are low unless the current transition raises them.
            r_ack       <= 1'b0;
            r_dat       <= '0;
            r_start     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_win   <= WIN_QUERY;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_act && !r_ack) begin
                        if (w_dec.is_reg) begin
                            r_reg_sel <= w_dec.reg_sel;
                            r_state   <= ST_REG;
                        end else if (w_dec.is_win && r_mode) begin
                            r_mem_req   <= 1'b1;
                            r_mem_win   <= w_dec.win;
                            r_mem_addr  <= wbs_adr_i[MEM_AW-1:0];
                            r_mem_we    <= wbs_we_i;
                            r_mem_be    <= wbs_sel_i;
                            r_mem_wdata <= wbs_dat_i;
                            r_state     <= ST_MREQ;
                        end else begin
                            // Unmapped or mode-gated window: ack with zero data, drop writes.
                            r_ack      <= 1'b1;
                            r_unmapped <= r_unmapped | w_dec.unmapped;
                            r_state    <= ST_ACK;
                        end
                    end
                end

                ST_REG: begin
                    if (!w_act) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                        if (wbs_we_i) begin
                            case (r_reg_sel)
                                REG_MODE:  if (wbs_sel_i[0]) r_mode <= wbs_dat_i[0];
                                REG_DEBUG: begin
                                    for (int b = 0; b < 4; b++) begin
                                        if (wbs_sel_i[b]) r_debug[8*b +: 8] <= wbs_dat_i[8*b +: 8];
                                    end
                                end
                                REG_START: r_start <= wbs_dat_i[0];
                                default:   ;
                            endcase
                        end else begin
                            case (r_reg_sel)
                                REG_MODE:  r_dat <= {31'b0, r_mode};
                                REG_DEBUG: r_dat <= r_debug;
                                REG_DONE:  r_dat <= {31'b0, fsm_done_i};
                                REG_BUSY:  r_dat <= {31'b0, fsm_busy_i};
                                default:   r_dat <= '0;
                            endcase
                        end
                    end
                end

                ST_MREQ: begin
                    if (!w_act) begin
                        r_state <= ST_IDLE;
                    end else if (r_mem_we) begin
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt   <= CNT_W'(MEM_LAT - 1);
                        r_state <= ST_MWAIT;
                    end
                end

                ST_MWAIT: begin
                    if (!w_act) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        r_ack   <= 1'b1;
                        r_dat   <= mem_rdata_i;
                        r_state <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign mode_o      = r_mode;
    assign debug_o     = r_debug;
    assign fsm_start_o = r_start;
    assign mem_req_o   = r_mem_req;
    assign mem_win_o   = r_mem_win;
    assign mem_addr_o  = r_mem_addr;
    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_wdata_o = r_mem_wdata;
    assign unmapped_o  = r_unmapped;

endmodule

// File: tb/tb_wbs_slave_regmap.sv
// Scoreboard bench: two responders (memory latency 1 and 3) driven with directed
// Wishbone accesses; monitors check acks and memory requests against queued expectations.
module tb_wbs_slave_regmap;

    localparam int unsigned AW   = 12;
    localparam int unsigned LAT0 = 1;
    localparam int unsigned LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          stb[2], cyc[2], we[2], done[2], busy[2];
    logic [3:0]    sel[2];
    logic [31:0]   dat_i[2], adr[2];
    logic          ack[2], mode[2], start[2], mreq[2], mwe[2], unm[2];
    logic [31:0]   dat_o[2], dbg[2], mwdata[2], mrdata[2];
    logic [1:0]    mwin[2];
    logic [AW-1:0] maddr[2];
    logic [3:0]    mbe[2];

    wbs_slave_regmap #(.MEM_AW(AW), .MEM_LAT(LAT0), .BASE_HI(16'h3000)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb[0]), .wbs_cyc_i(cyc[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]),
        .wbs_dat_i(dat_i[0]), .wbs_adr_i(adr[0]), .wbs_ack_o(ack[0]), .wbs_dat_o(dat_o[0]),
        .mode_o(mode[0]), .debug_o(dbg[0]), .fsm_start_o(start[0]),
        .fsm_done_i(done[0]), .fsm_busy_i(busy[0]),
        .mem_req_o(mreq[0]), .mem_win_o(mwin[0]), .mem_addr_o(maddr[0]), .mem_we_o(mwe[0]),
        .mem_be_o(mbe[0]), .mem_wdata_o(mwdata[0]), .mem_rdata_i(mrdata[0]), .unmapped_o(unm[0])
    );

    wbs_slave_regmap #(.MEM_AW(AW), .MEM_LAT(LAT1), .BASE_HI(16'h3000)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb[1]), .wbs_cyc_i(cyc[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]),
        .wbs_dat_i(dat_i[1]), .wbs_adr_i(adr[1]), .wbs_ack_o(ack[1]), .wbs_dat_o(dat_o[1]),
        .mode_o(mode[1]), .debug_o(dbg[1]), .fsm_start_o(start[1]),
        .fsm_done_i(done[1]), .fsm_busy_i(busy[1]),
        .mem_req_o(mreq[1]), .mem_win_o(mwin[1]), .mem_addr_o(maddr[1]), .mem_we_o(mwe[1]),
        .mem_be_o(mbe[1]), .mem_wdata_o(mwdata[1]), .mem_rdata_i(mrdata[1]), .unmapped_o(unm[1])
    );

    typedef struct {
        int          d;
        logic [31:0] data;
        int          cyc;
        logic        start;
    } ack_exp_t;

    typedef struct {
        int          d;
        logic        we;
        logic [1:0]  win;
        logic [AW-1:0] addr;
        logic [31:0] wdata;
    } req_exp_t;

    ack_exp_t aq[$];
    req_exp_t rq[$];
    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] mem_def(input int d, input logic [1:0] w, input logic [AW-1:0] a);
        return 32'h5A00_0000 | (32'(d) << 20) | (32'(w) << 16) | 32'(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Memory model: word store per DUT plus a read pipeline that drives data
    // only on the exact cycle it is due, garbage otherwise.
    logic        pv[2][4];
    logic [31:0] pd[2][4];
    logic [31:0] mem[2][4][16];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int s = 0; s < 4; s++) begin
                    pv[d][s] <= 1'b0;
                    pd[d][s] <= '0;
                end
                for (int w = 0; w < 4; w++)
                    for (int i = 0; i < 16; i++)
                        mem[d][w][i] <= mem_def(d, 2'(w), AW'(i));
            end else begin
                for (int s = 3; s > 0; s--) begin
                    pv[d][s] <= pv[d][s-1];
                    pd[d][s] <= pd[d][s-1];
                end
                pv[d][0] <= mreq[d] && !mwe[d];
                pd[d][0] <= mem[d][mwin[d]][maddr[d][3:0]];
                if (mreq[d] && mwe[d]) mem[d][mwin[d]][maddr[d][3:0]] <= mwdata[d];
            end
        end
    end

    assign mrdata[0] = pv[0][LAT0-1] ? pd[0][LAT0-1] : 32'hDEAD_BEEF;
    assign mrdata[1] = pv[1][LAT1-1] ? pd[1][LAT1-1] : 32'hDEAD_BEEF;

    // Monitor: pops expectations whenever an ack or memory request appears.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (ack[d]) begin
                    if (aq.size() == 0 || aq[0].d != d) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ack: dut%0d got ack data %h want no ack (cycle %0d)",
                                 d, dat_o[d], cyc_n);
                    end else begin
                        ack_exp_t e;
                        e = aq.pop_front();
                        chk("ack_data",  dat_o[d], e.data);
                        chk("ack_cycle", 32'(cyc_n), 32'(e.cyc));
                        chk("ack_start", 32'(start[d]), 32'(e.start));
                    end
                end else begin
                    chk("dat_idle",   dat_o[d], 32'h0);
                    chk("start_idle", 32'(start[d]), 32'h0);
                end
                if (mreq[d]) begin
                    if (rq.size() == 0 || rq[0].d != d) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req: dut%0d got req win=%0d addr=%h we=%0b want none",
                                 d, mwin[d], maddr[d], mwe[d]);
                    end else begin
                        req_exp_t r;
                        r = rq.pop_front();
                        chk("req_we",   32'(mwe[d]),   32'(r.we));
                        chk("req_win",  32'(mwin[d]),  32'(r.win));
                        chk("req_addr", 32'(maddr[d]), 32'(r.addr));
                        chk("req_be",   32'(mbe[d]),   32'hF);
                        if (r.we) chk("req_wdata", mwdata[d], r.wdata);
                    end
                end
            end
        end
    end

    task automatic exp_req(input int d, input logic w, input logic [1:0] win,
                           input logic [AW-1:0] a, input logic [31:0] wd);
        req_exp_t r;
        r.d = d; r.we = w; r.win = win; r.addr = a; r.wdata = wd;
        rq.push_back(r);
    endtask

    // One access; expected ack lands lat cycles after the first cyc&stb cycle.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic [31:0] exp, input int lat,
                        input logic exp_start, input logic keep);
        ack_exp_t e;
        int n;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_i[d] = wd; sel[d] = s;
        e.d = d; e.data = exp; e.cyc = cyc_n + lat; e.start = exp_start;
        aq.push_back(e);
        n = 0;
        while (!ack[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ack[d]) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: dut%0d adr %h got no ack want ack", d, a);
        end
        @(posedge clk); #1;
        if (!keep) begin
            cyc[d] = 1'b0; stb[d] = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    // Access abandoned n cycles after it starts by dropping cyc (stb follows a cycle later).
    task automatic abort_at(input int d, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input int n);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_i[d] = wd; sel[d] = 4'hF;
        repeat (n) begin @(posedge clk); #1; end
        cyc[d] = 1'b0;
        @(posedge clk); #1;
        stb[d] = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            stb[d] = 0; cyc[d] = 0; we[d] = 0; sel[d] = '0; dat_i[d] = '0; adr[d] = '0;
            done[d] = 0; busy[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            chk("rst_mode",  32'(mode[d]), 0);
            chk("rst_debug", dbg[d],       0);
            chk("rst_unm",   32'(unm[d]),  0);
            chk("rst_ack",   32'(ack[d]),  0);
            chk("rst_req",   32'(mreq[d]), 0);
        end

        // ---- DUT0, memory latency 1 ----
        xfer(0, 1, 32'h3000_0000, 32'h1, 4'hF, 32'h0, 2, 0, 0);
        chk("mode_set", 32'(mode[0]), 1);
        xfer(0, 0, 32'h3000_0000, 32'h0, 4'hF, 32'h1, 2, 0, 0);

        xfer(0, 1, 32'h3000_0004, 32'h1234_5678, 4'hF, 32'h0, 2, 0, 0);
        xfer(0, 1, 32'h3000_0004, 32'hAABB_CCDD, 4'h5, 32'h0, 2, 0, 0);
        chk("debug_lanes", dbg[0], 32'h12BB_56DD);
        xfer(0, 0, 32'h3000_0004, 32'h0, 4'hF, 32'h12BB_56DD, 2, 0, 0);

        // Node write then back-to-back read with only we flipped.
        exp_req(0, 1, 2'd3, 12'h001, 32'h0001_B801);
        xfer(0, 1, 32'h3004_0001, 32'h0001_B801, 4'hF, 32'h0, 2, 0, 1);
        exp_req(0, 0, 2'd3, 12'h001, 32'h0);
        xfer(0, 0, 32'h3004_0001, 32'h0001_B801, 4'hF, 32'h0001_B801, 3, 0, 0);

        // Leaf read with high address bits set and adr[1:0]!=0.
        exp_req(0, 0, 2'd1, 12'h00A, 32'h0);
        xfer(0, 0, 32'h3002_F00A, 32'h0, 4'hF, mem_def(0, 2'd1, 12'h00A), 3, 0, 0);

        xfer(0, 1, 32'h3000_000C, 32'h1, 4'hF, 32'h0, 2, 1, 0);
        xfer(0, 1, 32'h3000_000C, 32'h0, 4'hF, 32'h0, 2, 0, 0);
        xfer(0, 0, 32'h3000_000C, 32'h0, 4'hF, 32'h0, 2, 0, 0);

        done[0] = 1'b1; busy[0] = 1'b0;
        xfer(0, 0, 32'h3000_0008, 32'h0, 4'hF, 32'h1, 2, 0, 0);
        xfer(0, 0, 32'h3000_0010, 32'h0, 4'hF, 32'h0, 2, 0, 0);
        busy[0] = 1'b1;
        xfer(0, 0, 32'h3000_0010, 32'h0, 4'hF, 32'h1, 2, 0, 0);

        xfer(0, 1, 32'h3000_0000, 32'h0, 4'hE, 32'h0, 2, 0, 0);
        chk("mode_sel0_gate", 32'(mode[0]), 1);
        xfer(0, 1, 32'h3000_0000, 32'h0, 4'h1, 32'h0, 2, 0, 0);
        chk("mode_clear", 32'(mode[0]), 0);

        // Mode 0: windows acked directly with no memory traffic.
        xfer(0, 1, 32'h3001_0005, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 0, 0);
        xfer(0, 0, 32'h3002_0003, 32'h0, 4'hF, 32'h0, 1, 0, 0);
        chk("unm_not_yet", 32'(unm[0]), 0);

        xfer(0, 0, 32'h3000_0014, 32'h0, 4'hF, 32'h0, 1, 0, 0);
        chk("unm_set", 32'(unm[0]), 1);
        xfer(0, 1, 32'h3000_0002, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 0, 0);
        xfer(0, 0, 32'h3005_0000, 32'h0, 4'hF, 32'h0, 1, 0, 0);
        xfer(0, 0, 32'h2FFF_0000, 32'h0, 4'hF, 32'h0, 1, 0, 0);
        xfer(0, 0, 32'h3000_0004, 32'h0, 4'hF, 32'h12BB_56DD, 2, 0, 0);
        chk("unm_sticky", 32'(unm[0]), 1);
        chk("mode_after_unm", 32'(mode[0]), 0);

        // ---- DUT1, memory latency 3 ----
        xfer(1, 1, 32'h3000_0000, 32'h1, 4'hF, 32'h0, 2, 0, 0);
        exp_req(1, 0, 2'd2, 12'h007, 32'h0);
        xfer(1, 0, 32'h3003_0007, 32'h0, 4'hF, mem_def(1, 2'd2, 12'h007), 5, 0, 0);

        exp_req(1, 0, 2'd2, 12'h008, 32'h0);
        abort_at(1, 0, 32'h3003_0008, 32'h0, 2);
        exp_req(1, 0, 2'd2, 12'h009, 32'h0);
        xfer(1, 0, 32'h3003_0009, 32'h0, 4'hF, mem_def(1, 2'd2, 12'h009), 5, 0, 0);

        abort_at(1, 1, 32'h3000_0004, 32'hFFFF_FFFF, 1);
        chk("reg_abort_no_write", dbg[1], 32'h0);

        exp_req(1, 1, 2'd1, 12'h003, 32'hABCD_0123);
        abort_at(1, 1, 32'h3002_0003, 32'hABCD_0123, 1);
        exp_req(1, 0, 2'd1, 12'h003, 32'h0);
        xfer(1, 0, 32'h3002_0003, 32'h0, 4'hF, 32'hABCD_0123, 5, 0, 0);

        xfer(1, 1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF, 32'h0, 2, 0, 0);
        xfer(1, 0, 32'h3000_0020, 32'h0, 4'hF, 32'h0, 1, 0, 0);
        chk("unm1_set", 32'(unm[1]), 1);
        chk("debug1",   dbg[1], 32'hCAFE_F00D);

        // Reset while waiting on memory: everything clears, transaction is dropped.
        exp_req(1, 0, 2'd3, 12'h002, 32'h0);
        cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h3004_0002; sel[1] = 4'hF;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc[1] = 0; stb[1] = 0;
        chk("mrst_ack",   32'(ack[1]),   0);
        chk("mrst_dat",   dat_o[1],      0);
        chk("mrst_mode",  32'(mode[1]),  0);
        chk("mrst_debug", dbg[1],        0);
        chk("mrst_unm",   32'(unm[1]),   0);
        chk("mrst_req",   32'(mreq[1]),  0);
        chk("mrst_start", 32'(start[1]), 0);
        repeat (8) begin @(posedge clk); #1; end

        chk("ack_queue_empty", 32'(aq.size()), 0);
        chk("req_queue_empty", 32'(rq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
